// File: rtl/retire_controller_pkg.sv
// Shared types for the in-order retire sequencer: FSM state, ROB head bundle,
// and the architectural regfile write packet.
package retire_controller_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2,
    HALT       = 2'd3
  } RETIRE_STATE;

  // The head tag is kept out of the bundle because its width is set per instance.
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [4:0]  dest;
    logic [31:0] value;
    logic        is_store;
    logic        mispredict;
    logic [31:0] target_pc;
    logic        halt;
  } ROB_HEAD_PACKET;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } RETIRE_RF_PACKET;

  function automatic RETIRE_RF_PACKET rf_commit(input ROB_HEAD_PACKET h);
    RETIRE_RF_PACKET r;
    r.we    = (h.dest != '0);
    r.waddr = h.dest;
    r.wdata = h.value;
    return r;
  endfunction

endpackage

// File: rtl/retire_controller_if.sv
// ROB head / commit-side bundle; master is the retire controller, slave is the
// ROB, regfile, D-cache and fetch side.
interface retire_controller_if #(
  parameter int unsigned TAG_W = 6
);
  logic             head_valid;
  logic             head_ready;
  logic [TAG_W-1:0] head_tag;
  logic [4:0]       head_dest;
  logic [31:0]      head_value;
  logic             head_is_store;
  logic             head_mispredict;
  logic [31:0]      head_target_pc;
  logic             head_halt;
  logic             mem_ack;

  logic             retire_entry;
  logic             rob_clear;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             st_req;
  logic [TAG_W-1:0] st_tag;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             dispatch_stall;
  logic             halted;
  logic [31:0]      retired_count;

  modport master (
    input  head_valid, head_ready, head_tag, head_dest, head_value,
           head_is_store, head_mispredict, head_target_pc, head_halt, mem_ack,
    output retire_entry, rob_clear, rf_we, rf_waddr, rf_wdata, st_req, st_tag,
           redirect_valid, redirect_pc, dispatch_stall, halted, retired_count
  );

  modport slave (
    output head_valid, head_ready, head_tag, head_dest, head_value,
           head_is_store, head_mispredict, head_target_pc, head_halt, mem_ack,
    input  retire_entry, rob_clear, rf_we, rf_waddr, rf_wdata, st_req, st_tag,
           redirect_valid, redirect_pc, dispatch_stall, halted, retired_count
  );
endinterface

// File: rtl/retire_controller.sv
// In-order commit sequencer: retires the ROB head, commits stores through a
// D-cache handshake, flushes on mispredict and parks on halt.
module retire_controller
  import retire_controller_pkg::*;
#(
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic                 clock,
  input logic                 reset,
  retire_controller_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  RETIRE_STATE      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      target_q, target_d;
  logic [31:0]      count_q;

  ROB_HEAD_PACKET   head;
  RETIRE_RF_PACKET  rf;
  logic             retire, clear, st_req, redir, stall;
  logic [TAG_W-1:0] st_tag;
  logic [31:0]      rpc;

  always_comb begin
    head = '{valid:      bus.head_valid,
             ready:      bus.head_ready,
             dest:       bus.head_dest,
             value:      bus.head_value,
             is_store:   bus.head_is_store,
             mispredict: bus.head_mispredict,
             target_pc:  bus.head_target_pc,
             halt:       bus.head_halt};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    target_d = target_q;
    retire   = 1'b0;
    clear    = 1'b0;
    rf       = '0;
    st_req   = 1'b0;
    st_tag   = '0;
    redir    = 1'b0;
    rpc      = '0;
    stall    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (head.valid && head.ready) begin
          if (head.halt) begin
            retire  = 1'b1;
            state_d = HALT;
          end else if (head.is_store) begin
            tag_d   = bus.head_tag;
            state_d = STORE_WAIT;
          end else begin
            retire = 1'b1;
            rf     = rf_commit(head);
            if (head.mispredict) begin
              target_d = head.target_pc;
              cnt_d    = FLUSH_LOAD;
              state_d  = FLUSH;
            end
          end
        end
      end
      STORE_WAIT: begin
        st_req = 1'b1;
        st_tag = tag_q;
        if (bus.mem_ack) begin
          retire  = 1'b1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        stall = 1'b1;
        // A full counter marks the first flush cycle, the only one that clears and redirects.
        if (cnt_q == FLUSH_LOAD) begin
          clear = 1'b1;
          redir = 1'b1;
          rpc   = target_q;
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = RUN;
      end
      HALT: stall = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      tag_q    <= '0;
      target_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      count_q  <= count_q + 32'(retire);
    end
  end

  assign bus.retire_entry   = retire;
  assign bus.rob_clear      = clear;
  assign bus.rf_we          = rf.we;
  assign bus.rf_waddr       = rf.waddr;
  assign bus.rf_wdata       = rf.wdata;
  assign bus.st_req         = st_req;
  assign bus.st_tag         = st_tag;
  assign bus.redirect_valid = redir;
  assign bus.redirect_pc    = rpc;
  assign bus.dispatch_stall = stall;
  assign bus.halted         = (state_q == HALT);
  assign bus.retired_count  = count_q;

endmodule

// File: tb/tb_retire_controller.sv
// Scoreboard bench for retire_controller: stimulus predicts each cycle's
// outputs from the commit rules, a negedge monitor pops and compares.
module tb_retire_controller;

  localparam int unsigned TAG_W     = 6;
  localparam int unsigned FLUSH_CYC = 2;

  logic clock;
  logic reset;

  retire_controller_if #(.TAG_W(TAG_W)) bus ();

  retire_controller #(.TAG_W(TAG_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    bit          retire;
    bit          clear;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          st_req;
    logic [5:0]  st_tag;
    bit          redir;
    logic [31:0] rpc;
    bit          stall;
    bit          halted;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cycnum = 0;

  // Reference model: what the commit rules say is outstanding.
  bit          m_halted;
  bit          m_store;
  logic [5:0]  m_tag;
  int          m_flush_left;
  bit          m_first;
  logic [31:0] m_target;
  logic [31:0] m_count;

  task automatic model_reset();
    m_halted     = 1'b0;
    m_store      = 1'b0;
    m_tag        = '0;
    m_flush_left = 0;
    m_first      = 1'b0;
    m_target     = '0;
    m_count      = '0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset              = 1'b1;
    bus.head_valid     = 1'b0;
    bus.mem_ack        = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input bit v, input bit r, input bit st, input bit mp,
                       input bit hlt, input bit ack, input logic [5:0] tag,
                       input logic [4:0] dest, input logic [31:0] val,
                       input logic [31:0] tgt);
    exp_t e;
    @(posedge clock);
    #1;
    reset               = 1'b0;
    bus.head_valid      = v;
    bus.head_ready      = r;
    bus.head_is_store   = st;
    bus.head_mispredict = mp;
    bus.head_halt       = hlt;
    bus.mem_ack         = ack;
    bus.head_tag        = tag;
    bus.head_dest       = dest;
    bus.head_value      = val;
    bus.head_target_pc  = tgt;
    cycnum++;

    e.cyc = cycnum; e.retire = 0; e.clear = 0; e.we = 0; e.waddr = '0;
    e.wdata = '0; e.st_req = 0; e.st_tag = '0; e.redir = 0; e.rpc = '0;
    e.stall = 0; e.halted = m_halted; e.count = m_count;

    if (m_halted) begin
      e.stall = 1;
    end else if (m_flush_left > 0) begin
      e.stall = 1;
      if (m_first) begin
        e.clear = 1;
        e.redir = 1;
        e.rpc   = m_target;
      end
      m_first = 1'b0;
      m_flush_left--;
    end else if (m_store) begin
      e.st_req = 1;
      e.st_tag = m_tag;
      if (ack) begin
        e.retire = 1;
        m_store  = 1'b0;
      end
    end else if (v && r) begin
      if (hlt) begin
        e.retire = 1;
        m_halted = 1'b1;
      end else if (st) begin
        m_store = 1'b1;
        m_tag   = tag;
      end else begin
        e.retire = 1;
        e.we     = (dest != 0);
        e.waddr  = dest;
        e.wdata  = val;
        if (mp) begin
          m_flush_left = FLUSH_CYC;
          m_first      = 1'b1;
          m_target     = tgt;
        end
      end
    end
    if (e.retire) m_count = m_count + 1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (bus.retire_entry !== e.retire || bus.rob_clear !== e.clear ||
          bus.rf_we !== e.we || bus.rf_waddr !== e.waddr ||
          bus.rf_wdata !== e.wdata || bus.st_req !== e.st_req ||
          bus.st_tag !== e.st_tag || bus.redirect_valid !== e.redir ||
          bus.redirect_pc !== e.rpc || bus.dispatch_stall !== e.stall ||
          bus.halted !== e.halted || bus.retired_count !== e.count) begin
        fails++;
        $display("FAIL cycle_%0d got ret=%b clr=%b we=%b wa=%0d wd=%h st=%b tag=%0d rv=%b rpc=%h stall=%b halt=%b cnt=%0d expected ret=%b clr=%b we=%b wa=%0d wd=%h st=%b tag=%0d rv=%b rpc=%h stall=%b halt=%b cnt=%0d",
                 e.cyc, bus.retire_entry, bus.rob_clear, bus.rf_we, bus.rf_waddr,
                 bus.rf_wdata, bus.st_req, bus.st_tag, bus.redirect_valid,
                 bus.redirect_pc, bus.dispatch_stall, bus.halted, bus.retired_count,
                 e.retire, e.clear, e.we, e.waddr, e.wdata, e.st_req, e.st_tag,
                 e.redir, e.rpc, e.stall, e.halted, e.count);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int halt_age;
    bit v, r, st, mp, hlt, ack;
    reset = 1'b1;
    bus.head_valid = 0; bus.head_ready = 0; bus.head_is_store = 0;
    bus.head_mispredict = 0; bus.head_halt = 0; bus.mem_ack = 0;
    bus.head_tag = '0; bus.head_dest = '0; bus.head_value = '0;
    bus.head_target_pc = '0;
    model_reset();
    do_reset();
    do_reset();

    // Reset then idle.
    idle(5);

    // Back-to-back ALU retires, including a dest-0 instruction.
    cycle(1, 1, 0, 0, 0, 0, 6'd1, 5'd1, 32'hFFFF_FFFF, '0);
    cycle(1, 1, 0, 0, 0, 0, 6'd2, 5'd2, 32'd2, '0);
    cycle(1, 1, 0, 0, 0, 0, 6'd3, 5'd8, 32'd3, '0);
    cycle(1, 1, 0, 0, 0, 0, 6'd4, 5'd0, 32'd7, '0);
    cycle(1, 0, 0, 0, 0, 0, 6'd5, 5'd3, 32'd9, '0);
    idle(1);

    // Store with three cycles of back-pressure, plus a stray ack beforehand.
    cycle(0, 0, 0, 0, 0, 1, '0, '0, '0, '0);
    cycle(1, 1, 1, 0, 0, 0, 6'd5, 5'd4, 32'h55, '0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0, 6'd5, 5'd4, 32'h55, '0);
    cycle(1, 1, 1, 0, 0, 1, 6'd5, 5'd4, 32'h55, '0);
    idle(1);

    // Mispredict: ready heads during the flush must not retire.
    cycle(1, 1, 0, 1, 0, 0, 6'd7, 5'd1, 32'h1234, 32'h0000_0040);
    cycle(1, 1, 0, 0, 0, 0, 6'd8, 5'd2, 32'hAA, '0);
    cycle(1, 1, 0, 0, 0, 0, 6'd8, 5'd2, 32'hAA, '0);
    cycle(1, 1, 0, 0, 0, 0, 6'd8, 5'd2, 32'hAA, '0);
    idle(1);

    // Halt is sticky until reset.
    cycle(1, 1, 0, 0, 1, 0, 6'd9, 5'd0, '0, '0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 1, 6'd10, 5'd3, 32'h77, '0);
    do_reset();
    idle(2);

    // Reset while a store is pending.
    cycle(1, 1, 0, 0, 0, 0, 6'd11, 5'd5, 32'h99, '0);
    cycle(1, 1, 1, 0, 0, 0, 6'd12, 5'd0, '0, '0);
    cycle(1, 1, 1, 0, 0, 0, 6'd12, 5'd0, '0, '0);
    cycle(1, 1, 1, 0, 0, 0, 6'd12, 5'd0, '0, '0);
    do_reset();
    idle(2);

    // Randomized traffic.
    halt_age = 0;
    for (int n = 0; n < 1500; n++) begin
      if (m_halted) halt_age++;
      else halt_age = 0;
      if (halt_age > 3 || $urandom_range(199) == 0) begin
        do_reset();
        halt_age = 0;
      end
      v   = ($urandom_range(9) < 8);
      r   = ($urandom_range(9) < 7);
      st  = ($urandom_range(9) < 2);
      mp  = ($urandom_range(9) < 2);
      hlt = ($urandom_range(99) < 3);
      ack = ($urandom_range(9) < 4);
      cycle(v, r, st, mp, hlt, ack, 6'($urandom), 5'($urandom_range(3) == 0 ? 0 : $urandom),
            $urandom, $urandom);
    end
    idle(2);

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain remaining=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
